// File: rtl/bufarb_pkg.sv
// bufarb_pkg: encodings shared by the buffer ownership arbiter and the
// rxbuf/txbuf instantiation glue.
//   MODE_*    : adr_mode select values driven into a buffer's adr_mode_i
//   state_e   : arbiter state encoding
//   arbitrate : fixed-priority pick ETH > DMA > BUS, with a one-shot DMA skip
//   state_mode: adr_mode value that belongs to an owner state
package bufarb_pkg;

  localparam logic [1:0] MODE_BUS = 2'b00;
  localparam logic [1:0] MODE_DMA = 2'b01;
  localparam logic [1:0] MODE_ETH = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BUS   = 3'd1,
    ST_DMA   = 3'd2,
    ST_ETH   = 3'd3,
    ST_GUARD = 3'd4
  } state_e;

  // After a DMA preemption the DMA request is ignored once so that the
  // waiting CPU bus actually gets the buffer.
  function automatic state_e arbitrate(input logic eth_req, input logic dma_req,
                                       input logic bus_req, input logic skip_dma);
    if (eth_req)                   return ST_ETH;
    else if (dma_req && !skip_dma) return ST_DMA;
    else if (bus_req)              return ST_BUS;
    else                           return ST_IDLE;
  endfunction

  // Idle and guard-exit-to-idle park the buffer in bus mode, which is
  // write-safe because the buffer gates writes with the bus strobe.
  function automatic logic [1:0] state_mode(input state_e st);
    case (st)
      ST_DMA:  return MODE_DMA;
      ST_ETH:  return MODE_ETH;
      default: return MODE_BUS;
    endcase
  endfunction

endpackage

// File: rtl/bufarb.sv
// bufarb: ownership arbiter and adr_mode sequencer for one RX/TX packet buffer.
// Grants the shared buffer port to the CPU bus, the DMA engine or the MAC,
// inserts GUARD idle cycles on every ownership change and bounds DMA hold
// time to HOLD_MAX cycles while the bus is waiting.
//   wb_clk_i   : clock
//   wb_rst_i   : synchronous active-high reset
//   bus_req_i  : CPU bus request (level)
//   dma_req_i  : DMA request (level)
//   eth_req_i  : MAC request (level)
//   bus_gnt_o  : bus owns the buffer
//   dma_gnt_o  : DMA owns the buffer
//   eth_gnt_o  : MAC owns the buffer
//   adr_mode_o : buffer select (00 bus, 01 DMA, 10 Ethernet)
//   busy_o     : arbiter not idle (owner active or guard running)
//   preempt_o  : one-cycle pulse when a DMA grant is revoked by hold timeout
module bufarb
  import bufarb_pkg::*;
#(
  parameter int GUARD    = 1,
  parameter int HOLD_MAX = 64,
  parameter int HOLD_W   = 7
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       bus_req_i,
  input  logic       dma_req_i,
  input  logic       eth_req_i,
  output logic       bus_gnt_o,
  output logic       dma_gnt_o,
  output logic       eth_gnt_o,
  output logic [1:0] adr_mode_o,
  output logic       busy_o,
  output logic       preempt_o
);

  // Guard counter holds the number of guard cycles still to run after the
  // current one; re-arbitration happens when it reads zero.
  localparam logic [1:0]        GUARD_LAST = 2'(GUARD - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_MAX - 1);

  state_e            state_q, state_d;
  logic [1:0]        guard_q, guard_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              skip_q, skip_d;
  logic [1:0]        mode_q, mode_d;
  logic              preempt_d;
  logic              bus_gnt_q, dma_gnt_q, eth_gnt_q, busy_q, preempt_q;
  state_e            arb_next;

  assign arb_next = arbitrate(eth_req_i, dma_req_i, bus_req_i, skip_q);

  always_comb begin
    // NOTE: every next-state variable gets a default here so no path through
    // the case below leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    guard_d   = guard_q;
    hold_d    = hold_q;
    skip_d    = skip_q;
    mode_d    = mode_q;
    preempt_d = 1'b0;

    case (state_q)
      ST_BUS: begin
        if (!bus_req_i) begin
          state_d = ST_GUARD;
          guard_d = GUARD_LAST;
        end
      end
      ST_ETH: begin
        if (!eth_req_i) begin
          state_d = ST_GUARD;
          guard_d = GUARD_LAST;
        end
      end
      ST_DMA: begin
        if (!dma_req_i) begin
          state_d = ST_GUARD;
          guard_d = GUARD_LAST;
        end else if (bus_req_i) begin
          if (hold_q == HOLD_LAST) begin
            state_d   = ST_GUARD;
            guard_d   = GUARD_LAST;
            preempt_d = 1'b1;
            skip_d    = 1'b1;
          end else if (hold_q != '1) begin
            hold_d = hold_q + 1'b1;
          end
        end else begin
          hold_d = '0;
        end
      end
      ST_GUARD: begin
        // adr_mode keeps the previous owner's value until the guard ends.
        if (guard_q != 2'd0) begin
          guard_d = guard_q - 2'd1;
        end else begin
          state_d = arb_next;
          mode_d  = state_mode(arb_next);
          hold_d  = '0;
          // The skip is spent once the bus is served or stops waiting.
          if (arb_next == ST_BUS || !bus_req_i) skip_d = 1'b0;
        end
      end
      default: begin  // ST_IDLE
        state_d = arb_next;
        mode_d  = state_mode(arb_next);
        hold_d  = '0;
        if (arb_next == ST_BUS || !bus_req_i) skip_d = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet
  // change in the same cycle as the state itself.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      guard_q   <= 2'd0;
      hold_q    <= '0;
      skip_q    <= 1'b0;
      mode_q    <= MODE_BUS;
      bus_gnt_q <= 1'b0;
      dma_gnt_q <= 1'b0;
      eth_gnt_q <= 1'b0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      hold_q    <= hold_d;
      skip_q    <= skip_d;
      mode_q    <= mode_d;
      bus_gnt_q <= (state_d == ST_BUS);
      dma_gnt_q <= (state_d == ST_DMA);
      eth_gnt_q <= (state_d == ST_ETH);
      busy_q    <= (state_d != ST_IDLE);
      preempt_q <= preempt_d;
    end
  end

  assign bus_gnt_o  = bus_gnt_q;
  assign dma_gnt_o  = dma_gnt_q;
  assign eth_gnt_o  = eth_gnt_q;
  assign adr_mode_o = mode_q;
  assign busy_o     = busy_q;
  assign preempt_o  = preempt_q;

endmodule

// File: tb/tb_bufarb.sv
// tb_bufarb: self-checking bench for bufarb. Two instances: dut_a with
// GUARD=1/HOLD_MAX=4 and dut_b with GUARD=3/HOLD_MAX=4. Each stimulus step
// pushes the expected output vector of the selected instance into a
// scoreboard queue; a monitor pops and compares it after the next edge.
// Vector layout: {preempt, busy, adr_mode[1:0], eth_gnt, dma_gnt, bus_gnt}.
module tb_bufarb;

  typedef struct {
    string      tag;
    bit         sel_b;
    logic [6:0] exp;
  } sb_entry_t;

  localparam logic [6:0] V_IDLE = 7'b0_0_00_000;
  localparam logic [6:0] V_BUS  = 7'b0_1_00_001;
  localparam logic [6:0] V_DMA  = 7'b0_1_01_010;
  localparam logic [6:0] V_ETH  = 7'b0_1_10_100;
  localparam logic [6:0] V_GB   = 7'b0_1_00_000;  // guard after bus
  localparam logic [6:0] V_GD   = 7'b0_1_01_000;  // guard after DMA
  localparam logic [6:0] V_GE   = 7'b0_1_10_000;  // guard after ETH
  localparam logic [6:0] V_PRE  = 7'b1_1_01_000;  // guard after preemption

  logic       clk = 1'b0;
  logic       rst;
  logic       a_bus, a_dma, a_eth, b_bus, b_dma, b_eth;
  logic       a_bus_gnt, a_dma_gnt, a_eth_gnt, a_busy, a_pre;
  logic       b_bus_gnt, b_dma_gnt, b_eth_gnt, b_busy, b_pre;
  logic [1:0] a_mode, b_mode;

  int n_tests = 0;
  int n_fail  = 0;
  sb_entry_t sb_q[$];

  always #5 clk = ~clk;

  bufarb #(.GUARD(1), .HOLD_MAX(4), .HOLD_W(3)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .bus_req_i(a_bus), .dma_req_i(a_dma), .eth_req_i(a_eth),
    .bus_gnt_o(a_bus_gnt), .dma_gnt_o(a_dma_gnt), .eth_gnt_o(a_eth_gnt),
    .adr_mode_o(a_mode), .busy_o(a_busy), .preempt_o(a_pre)
  );

  bufarb #(.GUARD(3), .HOLD_MAX(4), .HOLD_W(3)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .bus_req_i(b_bus), .dma_req_i(b_dma), .eth_req_i(b_eth),
    .bus_gnt_o(b_bus_gnt), .dma_gnt_o(b_dma_gnt), .eth_gnt_o(b_eth_gnt),
    .adr_mode_o(b_mode), .busy_o(b_busy), .preempt_o(b_pre)
  );

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs (away from the active edge) and record the
  // outputs expected after the following rising edge.
  task automatic step(input string tag, input bit r, input bit sel_b,
                      input bit bus, input bit dma, input bit eth,
                      input logic [6:0] exp);
    sb_entry_t e;
    @(negedge clk);
    rst   = r;
    a_bus = sel_b ? 1'b0 : bus;
    a_dma = sel_b ? 1'b0 : dma;
    a_eth = sel_b ? 1'b0 : eth;
    b_bus = sel_b ? bus : 1'b0;
    b_dma = sel_b ? dma : 1'b0;
    b_eth = sel_b ? eth : 1'b0;
    e.tag   = tag;
    e.sel_b = sel_b;
    e.exp   = exp;
    sb_q.push_back(e);
  endtask

  always @(posedge clk) begin
    sb_entry_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.sel_b)
        check(e.tag, {b_pre, b_busy, b_mode, b_eth_gnt, b_dma_gnt, b_bus_gnt}, e.exp);
      else
        check(e.tag, {a_pre, a_busy, a_mode, a_eth_gnt, a_dma_gnt, a_bus_gnt}, e.exp);
    end
  end

  initial begin
    rst = 1'b1;
    {a_bus, a_dma, a_eth, b_bus, b_dma, b_eth} = '0;

    // Reset state on both instances.
    step("rst_a",  1, 0, 0, 0, 0, V_IDLE);
    step("rst_b",  1, 1, 0, 0, 0, V_IDLE);

    // Single bus request, release, one guard cycle, back to idle.
    step("bus_gnt",    0, 0, 1, 0, 0, V_BUS);
    step("bus_hold",   0, 0, 1, 0, 0, V_BUS);
    step("bus_guard",  0, 0, 0, 0, 0, V_GB);
    step("bus_idle",   0, 0, 0, 0, 0, V_IDLE);

    // All three at once: ETH, then DMA, then BUS, each after a guard.
    step("pri_eth",    0, 0, 1, 1, 1, V_ETH);
    step("pri_eth2",   0, 0, 1, 1, 1, V_ETH);
    step("pri_geth",   0, 0, 1, 1, 0, V_GE);
    step("pri_dma",    0, 0, 1, 1, 0, V_DMA);
    step("pri_dma2",   0, 0, 1, 1, 0, V_DMA);
    step("pri_gdma",   0, 0, 1, 0, 0, V_GD);
    step("pri_bus",    0, 0, 1, 0, 0, V_BUS);
    step("pri_gbus",   0, 0, 0, 0, 0, V_GB);
    step("pri_idle",   0, 0, 0, 0, 0, V_IDLE);

    // DMA owner is not preempted by ETH; ETH waits for release plus guard.
    step("nop_dma",    0, 0, 0, 1, 0, V_DMA);
    for (int i = 0; i < 5; i++) step("nop_hold", 0, 0, 0, 1, 1, V_DMA);
    step("nop_guard",  0, 0, 0, 0, 1, V_GD);
    step("nop_eth",    0, 0, 0, 0, 1, V_ETH);
    step("nop_geth",   0, 0, 0, 0, 0, V_GE);
    step("nop_idle",   0, 0, 0, 0, 0, V_IDLE);

    // Hold timeout: exactly 4 DMA cycles with bus waiting, preempt pulse,
    // bus granted despite DMA still requesting, then DMA re-granted.
    step("hold_dma1",  0, 0, 0, 1, 0, V_DMA);
    step("hold_dma2",  0, 0, 1, 1, 0, V_DMA);
    step("hold_dma3",  0, 0, 1, 1, 0, V_DMA);
    step("hold_dma4",  0, 0, 1, 1, 0, V_DMA);
    step("hold_pre",   0, 0, 1, 1, 0, V_PRE);
    step("hold_bus",   0, 0, 1, 1, 0, V_BUS);
    step("hold_bus2",  0, 0, 1, 1, 0, V_BUS);
    step("hold_gbus",  0, 0, 0, 1, 0, V_GB);
    step("hold_redma", 0, 0, 0, 1, 0, V_DMA);
    step("hold_gdma",  0, 0, 0, 0, 0, V_GD);
    step("hold_idle",  0, 0, 0, 0, 0, V_IDLE);

    // Reset during ETH ownership; ETH re-granted right after reset lifts.
    step("rsteth_gnt", 0, 0, 0, 0, 1, V_ETH);
    step("rsteth_own", 0, 0, 0, 0, 1, V_ETH);
    step("rsteth_rst", 1, 0, 0, 0, 1, V_IDLE);
    step("rsteth_re",  0, 0, 0, 0, 1, V_ETH);
    step("rsteth_gua", 0, 0, 0, 0, 0, V_GE);
    step("rsteth_idl", 0, 0, 0, 0, 0, V_IDLE);

    // GUARD=3: a 2-cycle pulse inside the guard window is never granted.
    step("g3_bus",     0, 1, 1, 0, 0, V_BUS);
    step("g3_guard1",  0, 1, 0, 0, 0, V_GB);
    step("g3_pulse1",  0, 1, 1, 0, 0, V_GB);
    step("g3_pulse2",  0, 1, 1, 0, 0, V_GB);
    step("g3_idle",    0, 1, 0, 0, 0, V_IDLE);
    step("g3_idle2",   0, 1, 0, 0, 0, V_IDLE);

    // GUARD=3: a request held through the guard is granted at guard exit.
    step("g3h_bus",    0, 1, 1, 0, 0, V_BUS);
    step("g3h_g1",     0, 1, 0, 0, 1, V_GB);
    step("g3h_g2",     0, 1, 0, 0, 1, V_GB);
    step("g3h_g3",     0, 1, 0, 0, 1, V_GB);
    step("g3h_eth",    0, 1, 0, 0, 1, V_ETH);
    step("g3h_ge1",    0, 1, 0, 0, 0, V_GE);
    step("g3h_ge2",    0, 1, 0, 0, 0, V_GE);
    step("g3h_ge3",    0, 1, 0, 0, 0, V_GE);
    step("g3h_idle",   0, 1, 0, 0, 0, V_IDLE);

    repeat (2) @(negedge clk);
    check("sb_drain", 7'(sb_q.size()), 7'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
